// File: rtl/tx_symbol_mapper.sv
// tx_symbol_mapper: buffers {b2,b1} words in a FIFO and maps them into two 16-QAM symbols plus a matrix index behind a registered valid/ready stage
module tx_symbol_mapper #(
  parameter int N = 32,
  parameter int Q = 22,
  parameter int DEPTH = 4,
  parameter int FRAME_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [11:0]              in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             s_I_1,
  output logic [N-1:0]             s_Q_1,
  output logic [N-1:0]             s_I_2,
  output logic [N-1:0]             s_Q_2,
  output logic [2:0]               m_I_1,
  output logic [2:0]               m_Q_1,
  output logic [2:0]               m_I_2,
  output logic [2:0]               m_Q_2,
  output logic [4:0]               q_idx,
  output logic                     frame_start,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              word_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
  localparam logic [N-1:0] ONE = N'(1) << Q;
  localparam logic [N-1:0] THREE = N'(3) << Q;
  function automatic logic [N-1:0] lvl(input logic [1:0] p);
    return p[1] ? (p[0] ? THREE : ONE) : (p[0] ? -ONE : -THREE);
  endfunction
  function automatic logic [2:0] idx(input logic [1:0] p);
    return {1'b0, p} + 3'd1;
  endfunction
  logic [11:0] mem_q [DEPTH];
  logic [11:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] level_q, level_d;
  logic out_valid_q, out_valid_d;
  logic [4*N-1:0] s_q, s_d;
  logic [11:0] m_q, m_d;
  logic [4:0] qi_q, qi_d;
  logic [15:0] wc_q, wc_d;
  logic [FW-1:0] fc_q, fc_d;
  logic push, pop, xfer;
  logic [11:0] head;
  always_comb begin
    head = mem_q[rd_q];
    push = in_valid && in_ready && !flush;
    xfer = out_valid_q && out_ready;
    pop = level_q != '0 && (!out_valid_q || out_ready);
    mem_d = mem_q;
    mem_d[wr_q] = push ? in_data : mem_q[wr_q];
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
    out_valid_d = !flush && (pop || (out_valid_q && !out_ready));
    s_d = pop ? {lvl(head[7:6]), lvl(head[5:4]), lvl(head[3:2]), lvl(head[1:0])} : s_q;
    m_d = pop ? {idx(head[7:6]), idx(head[5:4]), idx(head[3:2]), idx(head[1:0])} : m_q;
    qi_d = pop ? {1'b0, head[11:8]} : qi_q;
    wc_d = flush ? '0 : wc_q + 16'(xfer);
    fc_d = flush ? '0 : !xfer ? fc_q : fc_q == FW'(FRAME_LEN - 1) ? '0 : fc_q + FW'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      out_valid_q <= 1'b0;
      s_q <= '0;
      m_q <= '0;
      qi_q <= '0;
      wc_q <= '0;
      fc_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      level_q <= level_d;
      out_valid_q <= out_valid_d;
      s_q <= s_d;
      m_q <= m_d;
      qi_q <= qi_d;
      wc_q <= wc_d;
      fc_q <= fc_d;
    end
  end
  assign in_ready = level_q != LW'(DEPTH);
  assign out_valid = out_valid_q;
  assign {s_I_1, s_Q_1, s_I_2, s_Q_2} = s_q;
  assign {m_I_1, m_Q_1, m_I_2, m_Q_2} = m_q;
  assign q_idx = qi_q;
  assign frame_start = out_valid_q && fc_q == '0;
  assign fifo_level = level_q;
  assign word_count = wc_q;
endmodule

// File: tb/tb_tx_symbol_mapper.sv
// tb_tx_symbol_mapper: vector table, directed corner sequences and a randomized run against a queue-based reference model
module tb_tx_symbol_mapper;
  localparam int N = 32;
  localparam int Q = 22;
  localparam int DEPTH = 4;
  localparam int FRAME_LEN = 16;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [11:0] in_data = '0;
  logic in_ready, out_valid, frame_start;
  logic [N-1:0] s_I_1, s_Q_1, s_I_2, s_Q_2;
  logic [2:0] m_I_1, m_Q_1, m_I_2, m_Q_2;
  logic [4:0] q_idx;
  logic [2:0] fifo_level;
  logic [15:0] word_count;
  int checks = 0, errors = 0;
  logic [11:0] exp_q[$];
  int mcount = 0;
  bit have_prev = 0;
  logic [191:0] prev_snap;
  logic [11:0] w;
  logic [2:0] mv[4];
  logic [31:0] sv[4];
  int me;
  int fs_pos[$];
  int n, first, last;
  typedef struct {
    logic [11:0] d;
    logic [11:0] m;
    logic [127:0] s;
    logic [4:0] q;
  } vec_t;
  vec_t vec[5];
  always #5 clk = ~clk;
  tx_symbol_mapper #(.N(N), .Q(Q), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .s_I_1(s_I_1), .s_Q_1(s_Q_1), .s_I_2(s_I_2), .s_Q_2(s_Q_2),
    .m_I_1(m_I_1), .m_Q_1(m_Q_1), .m_I_2(m_I_2), .m_Q_2(m_Q_2),
    .q_idx(q_idx), .frame_start(frame_start), .fifo_level(fifo_level), .word_count(word_count)
  );
  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] lvl_of(input int m);
    return 32'((2 * m - 5) * (1 << Q));
  endfunction
  function automatic logic [1:0] pair_of(input logic [31:0] s);
    int v;
    v = ($signed(s) / (1 << Q) + 3) / 2;
    return 2'(v);
  endfunction
  function automatic logic [11:0] demap_s();
    return {q_idx[3:0], pair_of(s_I_1), pair_of(s_Q_1), pair_of(s_I_2), pair_of(s_Q_2)};
  endfunction
  function automatic logic [11:0] demap_m();
    return {q_idx[3:0], 2'(m_I_1 - 3'd1), 2'(m_Q_1 - 3'd1), 2'(m_I_2 - 3'd1), 2'(m_Q_2 - 3'd1)};
  endfunction
  function automatic logic [191:0] snap();
    return 192'({out_valid, s_I_1, s_Q_1, s_I_2, s_Q_2, m_I_1, m_Q_1, m_I_2, m_Q_2, q_idx, frame_start, word_count});
  endfunction
  task automatic wait_valid(input string name);
    int k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk(name, out_valid, 1);
  endtask
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mcount = 0;
      have_prev = 0;
    end else begin
      if (have_prev) chk("stall_hold", snap(), prev_snap);
      chk("occupancy", int'(fifo_level) + int'(out_valid), exp_q.size());
      chk("in_ready", in_ready, fifo_level != 3'(DEPTH));
      chk("word_count", word_count, 16'(mcount));
      chk("frame_start", frame_start, out_valid && (mcount % FRAME_LEN == 0));
      if (out_valid && exp_q.size() > 0) begin
        w = exp_q[0];
        mv = '{m_I_1, m_Q_1, m_I_2, m_Q_2};
        sv = '{s_I_1, s_Q_1, s_I_2, s_Q_2};
        for (int f = 0; f < 4; f++) begin
          me = int'((w >> (6 - 2 * f)) & 12'd3) + 1;
          chk("map_m", mv[f], me);
          chk("map_s", sv[f], lvl_of(me));
        end
        chk("map_q", q_idx, w >> 8);
        chk("loopback", demap_s(), w);
      end
      have_prev = out_valid && !out_ready && !flush;
      prev_snap = snap();
      if (flush) begin
        exp_q.delete();
        mcount = 0;
      end else begin
        if (out_valid && out_ready) begin
          void'(exp_q.pop_front());
          mcount++;
        end
        if (in_valid && in_ready) exp_q.push_back(in_data);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec[0] = '{12'h000, {3'd1, 3'd1, 3'd1, 3'd1}, {4{32'hFF400000}}, 5'd0};
    vec[1] = '{12'hF1B, {3'd1, 3'd2, 3'd3, 3'd4}, {32'hFF400000, 32'hFFC00000, 32'h00400000, 32'h00C00000}, 5'd15};
    vec[2] = '{12'hAE4, {3'd4, 3'd3, 3'd2, 3'd1}, {32'h00C00000, 32'h00400000, 32'hFFC00000, 32'hFF400000}, 5'd10};
    vec[3] = '{12'h5FF, {3'd4, 3'd4, 3'd4, 3'd4}, {4{32'h00C00000}}, 5'd5};
    vec[4] = '{12'h327, {3'd1, 3'd3, 3'd2, 3'd4}, {32'hFF400000, 32'h00400000, 32'hFFC00000, 32'h00C00000}, 5'd3};
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_wc", word_count, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_s", {s_I_1, s_Q_1, s_I_2, s_Q_2}, 0);
    chk("rst_m_q", {m_I_1, m_Q_1, m_I_2, m_Q_2, q_idx}, 0);
    @(posedge clk); #1 rst = 0;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      in_data = vec[i].d;
      @(posedge clk); #1 in_valid = 0;
      @(negedge clk);
      chk("lat_not_yet", out_valid, 0);
      @(negedge clk);
      chk("lat_valid", out_valid, 1);
      chk("vec_m", {m_I_1, m_Q_1, m_I_2, m_Q_2}, vec[i].m);
      chk("vec_s", {s_I_1, s_Q_1, s_I_2, s_Q_2}, vec[i].s);
      chk("vec_q", q_idx, vec[i].q);
      if (i == 0) chk("first_fs", frame_start, 1);
      @(posedge clk); #1;
      chk("wc_after_accept", word_count, i + 1);
    end
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1;
      in_data = 12'(12'h100 + i);
      @(negedge clk);
      if (i == 5) chk("bp_full_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(negedge clk);
    chk("bp_level", fifo_level, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(posedge clk); #1 out_ready = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_order", demap_m(), 12'(12'h100 + k));
      if (k == 1) chk("bp_ready_after_pop", in_ready, 1);
    end
    @(negedge clk);
    chk("bp_empty", out_valid, 0);
    @(posedge clk); #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    n = 0; first = -1; last = -1;
    for (int c = 0; c < 60; c++) begin
      in_valid = c < 40;
      in_data = 12'(c * 37);
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = c;
        last = c;
        if (frame_start) fs_pos.push_back(n);
        n++;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("stream_words", n, 40);
    chk("stream_contig", last - first + 1, 40);
    chk("stream_fs_cnt", fs_pos.size(), 3);
    if (fs_pos.size() == 3) chk("stream_fs_pos", {fs_pos[0], fs_pos[1], fs_pos[2]}, {32'd0, 32'd16, 32'd32});
    chk("stream_wc", word_count, 40);
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data = 12'(12'h300 + i);
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(negedge clk);
    chk("pre_flush_level", fifo_level, 3);
    @(posedge clk); #1 flush = 1;
    in_valid = 1;
    in_data = 12'h3AA;
    @(posedge clk); #1 flush = 0;
    in_valid = 0;
    @(negedge clk);
    chk("flush_level", fifo_level, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_wc", word_count, 0);
    @(posedge clk); #1 in_valid = 1;
    in_data = 12'h7C3;
    out_ready = 1;
    @(posedge clk); #1 in_valid = 0;
    wait_valid("post_flush_valid");
    chk("post_flush_fs", frame_start, 1);
    chk("post_flush_word", demap_m(), 12'h7C3);
    @(posedge clk); #1 out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data = 12'(12'h500 + i);
      @(posedge clk); #1;
    end
    in_valid = 0;
    chk("pre_rst_level", fifo_level, 3);
    #2 rst = 1;
    #1;
    chk("arst_level", fifo_level, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_wc", word_count, 0);
    chk("arst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst = 0;
    in_valid = 1;
    in_data = 12'h9E1;
    out_ready = 1;
    @(posedge clk); #1 in_valid = 0;
    wait_valid("post_rst_valid");
    chk("post_rst_fs", frame_start, 1);
    chk("post_rst_word", demap_m(), 12'h9E1);
    @(posedge clk); #1;
    for (int c = 0; c < 800; c++) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_data = 12'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 99) == 0;
      @(posedge clk); #1;
    end
    in_valid = 0;
    flush = 0;
    out_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("drain_valid", out_valid, 0);
    chk("drain_level", fifo_level, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
